// File: rtl/lsu_controller.sv
// Load/store sequencing controller between the execute stage and the synchronous
// data memory. It takes one memory operation at a time and stalls the pipeline
// while the req/gnt/rvalid handshake runs. It also does lane alignment, load
// extension, legality checks and a bus timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operation; accept, latch and check in one cycle
// REQ   | mem_req high, address/data held until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle done pulse with result/error flags, then back to IDLE
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic [3:0]  MemWrite,
    input  logic [1:0]  MemReadSize,
    input  logic        MemReadSigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_misaligned,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // The timer counts down from TIMEOUT_CYCLES-1. The terminal count is
    // zero, so REQ or WAIT gets exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tmr;
    logic        stall_q;
    logic        is_load_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;

    logic        op_present;
    logic        mask_ok;
    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic [31:0] store_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Operation decode and legality checks on the live execute-stage inputs
    always_comb begin
        op_present = ex_valid & (MemRead | (|MemWrite));
        mask_ok    = 1'b0;
        case (MemWrite)
            4'b0000, 4'b0001, 4'b0011, 4'b1111: mask_ok = 1'b1;
            default:                            mask_ok = 1'b0;
        endcase
        is_half = MemRead ? (MemReadSize == 2'd1) : (MemWrite == 4'b0011);
        is_word = MemRead ? (MemReadSize == 2'd2) : (MemWrite == 4'b1111);
        illegal = (MemRead & (|MemWrite))
                | ~mask_ok
                | (MemRead & (MemReadSize == 2'd3))
                | (is_half & addr[0])
                | (is_word & (addr[1:0] != 2'b00));
        case (MemWrite)
            4'b0001: store_data = {4{wdata[7:0]}};
            4'b0011: store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned read word
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // The accept cycle stalls combinationally. After that the stall is registered.
    assign stall = stall_q | (rst_n & (state == IDLE) & op_present);

    // Sequencing FSM with registered memory-side and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tmr            <= '0;
            stall_q        <= 1'b0;
            is_load_q      <= 1'b0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            lane_q         <= '0;
            done           <= 1'b0;
            rdata          <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_be         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            done           <= 1'b0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_present) begin
                        is_load_q <= MemRead;
                        size_q    <= MemReadSize;
                        signed_q  <= MemReadSigned;
                        lane_q    <= addr[1:0];
                        if (illegal) begin
                            state          <= RESP;
                            done           <= 1'b1;
                            err_misaligned <= 1'b1;
                        end else begin
                            state     <= REQ;
                            stall_q   <= 1'b1;
                            tmr       <= TMR_LOAD;
                            mem_req   <= 1'b1;
                            mem_we    <= ~MemRead;
                            mem_be    <= MemRead ? 4'b1111 : (MemWrite << addr[1:0]);
                            mem_addr  <= addr[31:2];
                            mem_wdata <= store_data;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (is_load_q) begin
                            state <= WAIT;
                            tmr   <= TMR_LOAD;
                        end else begin
                            state   <= RESP;
                            stall_q <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else if (tmr == 8'd0) begin
                        mem_req     <= 1'b0;
                        state       <= RESP;
                        stall_q     <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata   <= load_data;
                        state   <= RESP;
                        stall_q <= 1'b0;
                        done    <= 1'b1;
                    end else if (tmr == 8'd0) begin
                        state       <= RESP;
                        stall_q     <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store sequencing controller between the execute stage and the synchronous data memory of the RISC-V core. It accepts one decoded memory operation at a time, described by the MemRead, MemWrite byte mask, MemReadSize and MemReadSigned control signals. It stalls the pipeline while the access runs over a req/gnt/rvalid memory handshake. It performs byte-lane alignment, sign/zero extension, misalignment checks and a bus timeout.

## Interface
- TIMEOUT_CYCLES, default 255: cycles allowed in REQ or WAIT before aborting with err_timeout; range 1-255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ex_valid  in  1  execute stage holds a valid instruction.
- MemRead  in  1  load operation.
- MemWrite  in  4  store byte mask: 0001 SB, 0011 SH, 1111 SW, 0000 no store.
- MemReadSize  in  2  load size: 0 byte, 1 half, 2 word.
- MemReadSigned  in  1  sign-extend the load result (byte/half only).
- addr  in  32  byte address produced by the ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and pipeline registers.
- done  out  1  one-cycle completion pulse (RESP state).
- rdata  out  32  extended load result; valid while done=1 for loads.
- err_misaligned  out  1  pulse with done: misaligned or illegal operation; no memory access made.
- err_timeout  out  1  pulse with done: memory did not respond in time.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables.
- mem_addr  out  30  word address (addr[31:2]).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid; never earlier than the cycle after mem_gnt.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset enters IDLE. All outputs reset to 0. An active reset mid-access drops mem_req immediately and discards the operation.
- IDLE: an operation is present when ex_valid=1 and (MemRead=1 or MemWrite≠0). On a present operation: latch all inputs, assert stall combinationally in that same cycle, and run the legality checks.
- Illegal operations:
  - MemRead=1 with MemWrite≠0.
  - MemWrite not in {0001, 0011, 1111}.
  - MemReadSize=3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- Legal operation: IDLE→REQ. Illegal operation: IDLE→RESP with err_misaligned=1; mem_req is never raised.
- REQ: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata come from the latched values and are held stable until mem_gnt. On mem_gnt, a store goes to RESP and a load goes to WAIT.
- WAIT: on mem_rvalid, capture the extracted and extended data into rdata, then go to RESP.
- Timeout counter: cleared on entry to REQ and to WAIT, increments every cycle in those states. Reaching TIMEOUT_CYCLES without the awaited event deasserts mem_req and goes to RESP with err_timeout=1.
- RESP: stall=0, done=1 for exactly one cycle. Always returns to IDLE. ex_valid is ignored in RESP because the completing instruction is leaving the execute stage.
- Store lanes:
  - mem_be = MemWrite << addr[1:0].
  - mem_wdata = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
- Load extraction, with lane = addr[1:0]:
  - Byte: mem_rdata[8*lane+7 : 8*lane].
  - Half: mem_rdata[31:16] if lane[1], else mem_rdata[15:0].
  - Word: mem_rdata unchanged; MemReadSigned is ignored.
  - Byte and half results are sign-extended when MemReadSigned=1, zero-extended otherwise.
  - Loads drive mem_be=1111 and mem_we=0.
- stall=1 in IDLE with an operation present, and in REQ and WAIT. stall=0 otherwise.

## Timing
- Store, gnt in the first REQ cycle: accept cycle (stall=1) → REQ → RESP. Pipeline stalled for 2 cycles.
- Load, gnt in the first REQ cycle and rvalid one cycle later: IDLE → REQ → WAIT → RESP. Stalled for 3 cycles; rdata valid in the RESP cycle.
- Each extra cycle without gnt or rvalid adds one stall cycle.
- Illegal operation: one stall cycle, then RESP.
- Back-to-back operations: the earliest next accept is the cycle after RESP.
- mem_gnt and mem_rvalid are sampled only in REQ and WAIT respectively. Both are ignored in every other state.

## Test plan
- SB: addr=0x1003, wdata=0xA5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x400; done 2 cycles after accept.
- LH signed: addr=0x2002, mem_rdata=0x8001_1234 → rdata=0xFFFF8001. Same access as LHU → 0x00008001.
- LB signed: addr=0x2001, mem_rdata=0x0000_F000 → rdata=0xFFFFFFF0. LW: addr=0x2000 → rdata equals mem_rdata.
- LW at addr=0x2002 → err_misaligned=1 with done, mem_req stays 0, one stall cycle. Same result for MemWrite=0101.
- mem_gnt held low with TIMEOUT_CYCLES=4 → mem_req drops after 4 REQ cycles; err_timeout=1 and done=1 in RESP.
- rst_n low during WAIT → all outputs 0 immediately, state IDLE. A later mem_rvalid is ignored and the next load completes normally.
